// File: rtl/vga_trace_buffer.sv
// Trace buffer capturing processor VGA writes (address + data) into a FIFO with
// stop-when-full or circular-overwrite behaviour. Optional address window filter: TRACE_ADDR_FILTER_EN.
module vga_trace_buffer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WRAP       = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cap_en,
    input  logic [ADDR_WIDTH-1:0]         cap_addr,
    input  logic [DATA_WIDTH-1:0]         cap_data,
    input  logic                          arm,
    input  logic                          stop,
    input  logic                          rd_req,
`ifdef TRACE_ADDR_FILTER_EN
    input  logic [ADDR_WIDTH-1:0]         win_lo,
    input  logic [ADDR_WIDTH-1:0]         win_hi,
`endif
    output logic                          rd_valid,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    output logic [15:0]                   dropped,
    output logic [1:0]                    state
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    state_t                  state_reg;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [15:0]             dropped_reg;
    logic                    rd_valid_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic [DATA_WIDTH-1:0]   rd_data_reg;

    logic in_window;
    logic is_full;
    logic pop_fire;
    logic cap_fire;
    logic wr_accept;
    logic wr_overwrite;
    logic wr_lost;
    logic mem_we;

`ifdef TRACE_ADDR_FILTER_EN
    assign in_window = (cap_addr >= win_lo) && (cap_addr <= win_hi);
`else
    assign in_window = 1'b1;
`endif

    assign is_full  = (count_reg == CNT_W'(DEPTH));
    assign pop_fire = rd_req && (count_reg != '0);
    // An arm edge clears the buffer, so a strobe in that same cycle is dropped silently.
    assign cap_fire = (state_reg == ST_CAPTURE) && cap_en && in_window && !arm;

    // A simultaneous pop frees a slot, so a full buffer can still accept the write.
    assign wr_accept    = cap_fire && (!is_full || pop_fire);
    assign wr_lost      = cap_fire && is_full && !pop_fire;
    assign wr_overwrite = wr_lost && (WRAP != 0);
    assign mem_we       = (wr_accept || wr_overwrite) && !reset;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= {cap_addr, cap_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            dropped_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= pop_fire;
            if (pop_fire) begin
                {rd_addr_reg, rd_data_reg} <= mem[rd_ptr_reg];
            end

            if (arm) begin
                state_reg   <= ST_CAPTURE;
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                dropped_reg <= '0;
            end else begin
                if (stop && (state_reg == ST_CAPTURE)) begin
                    state_reg <= ST_DONE;
                end
                if (wr_accept || wr_overwrite) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                // Overwriting the oldest entry retires it just like a pop.
                if (pop_fire || wr_overwrite) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (wr_accept && !pop_fire) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop_fire && !wr_accept) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (wr_lost && (dropped_reg != 16'hFFFF)) begin
                    dropped_reg <= dropped_reg + 1'b1;
                end
            end
        end
    end

    assign state    = state_reg;
    assign count    = count_reg;
    assign full     = is_full;
    assign empty    = (count_reg == '0);
    assign dropped  = dropped_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_addr  = rd_addr_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: doc/vga_trace_buffer.md
VGA_TRACE_BUFFER -- requirements
Module: vga_trace_buffer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of captured VGA write address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of captured VGA write data.
REQ-003 SHALL have parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-004 SHALL have parameter WRAP, default 0: 0 = stop-when-full, 1 = circular overwrite of oldest entry.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cap_en  in  1  VGA write strobe from the processor MEM stage.
REQ-008 SHALL have port cap_addr  in  ADDR_WIDTH  VGA write address.
REQ-009 SHALL have port cap_data  in  DATA_WIDTH  VGA write data.
REQ-010 SHALL have port arm  in  1  start capture; clears buffer.
REQ-011 SHALL have port stop  in  1  end capture.
REQ-012 SHALL have port rd_req  in  1  pop oldest entry.
REQ-013 SHALL have port rd_valid  out  1  rd_addr/rd_data hold a popped entry this cycle.
REQ-014 SHALL have port rd_addr  out  ADDR_WIDTH  popped address.
REQ-015 SHALL have port rd_data  out  DATA_WIDTH  popped data.
REQ-016 SHALL have port count  out  clog2(DEPTH)+1  stored entries.
REQ-017 SHALL have ports full and empty  out  1 each  count==DEPTH, count==0.
REQ-018 SHALL have port dropped  out  16  saturating count of lost writes.
REQ-019 SHALL have port state  out  2  00 IDLE, 01 CAPTURE, 10 DONE.

Function
REQ-020 SHALL implement FSM IDLE -> CAPTURE on arm; CAPTURE -> DONE on stop; DONE -> CAPTURE on arm; arm and stop in the same cycle SHALL select arm.
REQ-021 SHALL, on arm, empty the buffer, zero dropped and reset pointers in that same edge; a cap_en in the arm cycle SHALL be ignored.
REQ-022 SHALL store {cap_addr, cap_data} at the write pointer only when state==CAPTURE and cap_en=1; writes in IDLE/DONE SHALL be ignored and not counted as dropped.
REQ-023 SHALL register reads: rd_req with empty=0 at edge N SHALL give rd_valid=1 and the oldest entry during cycle N+1; rd_req while empty SHALL be ignored, rd_valid=0.
REQ-024 SHALL permit reads in any state.
REQ-025 SHALL hold rd_addr/rd_data at last popped value when rd_valid=0.
REQ-026 SHALL, with WRAP=0 and full, reject a write without a simultaneous pop and increment dropped.
REQ-027 SHALL, with WRAP=1 and full, overwrite the oldest entry, advance the read pointer, keep count=DEPTH and increment dropped.
REQ-028 SHALL, on simultaneous accepted write and pop, leave count unchanged; when full the pop SHALL return the entry oldest before the edge.
REQ-029 SHALL wrap both pointers modulo DEPTH.
REQ-030 SHALL saturate dropped at 16'hFFFF.

Reset
REQ-031 SHALL, on reset at a rising edge, force state=IDLE, count=0, empty=1, full=0, dropped=0, rd_valid=0, rd_addr=0, rd_data=0, pointers=0.
REQ-032 SHALL let reset override arm, stop, cap_en and rd_req in the same cycle, including mid-capture.
REQ-033 SHALL not require memory array contents to be cleared by reset.

Configuration
REQ-034 SHALL, with TRACE_ADDR_FILTER_EN defined, add inputs win_lo and win_hi (ADDR_WIDTH each) and store only writes with win_lo <= cap_addr <= win_hi (unsigned).
REQ-035 SHALL not count out-of-window writes as dropped.
REQ-036 SHALL, without TRACE_ADDR_FILTER_EN, omit win_lo/win_hi and store every CAPTURE-state write.

Verification
REQ-037 SHALL test: reset, arm, 3 writes (0x010/0xA, 0x011/0xB, 0x012/0xC), stop, 3 rd_req -> rd_valid one cycle later each, data A,B,C in order, count 3->0, state DONE.
REQ-038 SHALL test: WRAP=0, DEPTH=16, 20 writes -> count=16, full=1, dropped=4, reads return writes 1-16.
REQ-039 SHALL test: WRAP=1, DEPTH=16, 20 writes -> count=16, dropped=4, reads return writes 5-20.
REQ-040 SHALL test: full buffer, cap_en and rd_req same cycle (WRAP=0) -> pop returns oldest, new entry stored, count stays 16, dropped unchanged.
REQ-041 SHALL test: reset asserted mid-capture with 5 entries -> next cycle state=IDLE, count=0, empty=1, dropped=0, rd_valid=0.
REQ-042 SHALL test: TRACE_ADDR_FILTER_EN, win 0x100-0x1FF, writes at 0x0FF, 0x100, 0x1FF, 0x200 -> count=2, dropped=0.
